// File: rtl/if_stage_pkg.sv
// Shared widths, exception codes and bus layouts for the IF stage and its neighbours.
// Also holds the discard-count update used when a flush hits with responses still outstanding.
package if_stage_pkg;

  localparam int         PFS_TO_FS_BUS_WD = 65;
  localparam int         FS_TO_DS_BUS_WD  = 70;
  localparam logic [4:0] EXCODE_ADEL      = 5'h04;
  localparam logic [1:0] DISCARD_MAX      = 2'd2;

  typedef struct packed {
    logic        inst_ok;
    logic [31:0] inst;
    logic [31:0] pc;
  } pfs_to_fs_bus_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_bus_t;

  // Responses still owed to the flushed IF/pre-IF fetches must be dropped when they return.
  function automatic logic [1:0] flush_discard(input logic [1:0] cnt,
                                               input logic       fs_wait,
                                               input logic       pfs_wait,
                                               input logic       data_ok);
    logic [2:0] sum;
    sum = {1'b0, cnt} + {2'b00, fs_wait} + {2'b00, pfs_wait};
    if (data_ok && (sum != 3'd0)) begin
      sum = sum - 3'd1;
    end
    if (sum > {1'b0, DISCARD_MAX}) begin
      sum = {1'b0, DISCARD_MAX};
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one fetched PC, waits for its instruction if pre-IF could not
// supply it, and hands it to decode; drops stale responses left behind by a writeback flush.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pfs_to_fs_valid,
  input  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
  output logic                        fs_allowin,
  output logic                        fs_valid,
  output logic                        fs_inst_unable,
  input  logic                        pfs_inst_waiting,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata,
  input  logic                        ds_allowin,
  output logic                        fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
  input  logic                        ws_ex,
  input  logic                        ws_eret
);

  logic        fs_valid_q, fs_valid_d;
  logic        fs_inst_buf_valid_q, fs_inst_buf_valid_d;
  logic [31:0] fs_inst_buf_q, fs_inst_buf_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;

  pfs_to_fs_bus_t pfs_bus;
  fs_to_ds_bus_t  ds_bus;
  logic           fs_ready_go;
  logic           fs_wait;
  logic           fs_take;
  logic           fs_accept;
  logic           flush;
  logic           fs_ex;

  assign pfs_bus        = pfs_to_fs_bus_t'(pfs_to_fs_bus);
  assign flush          = ws_ex || ws_eret;
  assign fs_ready_go    = fs_inst_buf_valid_q;
  assign fs_allowin     = !fs_valid_q || (fs_ready_go && ds_allowin);
  assign fs_accept      = pfs_to_fs_valid && fs_allowin;
  assign fs_wait        = fs_valid_q && !fs_inst_buf_valid_q;
  assign fs_take        = inst_sram_data_ok && fs_wait && (discard_cnt_q == 2'd0);
  assign fs_inst_unable = (discard_cnt_q == 2'd0) && !fs_wait;
  assign fs_valid       = fs_valid_q;
  assign fs_to_ds_valid = fs_valid_q && fs_ready_go && !flush;

  // A misaligned PC still waits for its response so the outstanding-request count stays in step.
  assign fs_ex          = (fs_pc_q[1:0] != 2'b00);
  assign ds_bus.ex      = fs_ex;
  assign ds_bus.excode  = fs_ex ? EXCODE_ADEL : 5'h00;
  assign ds_bus.inst    = fs_ex ? 32'h0 : fs_inst_buf_q;
  assign ds_bus.pc      = fs_pc_q;
  assign fs_to_ds_bus   = ds_bus;

  always_comb begin
    fs_valid_d          = fs_valid_q;
    fs_inst_buf_valid_d = fs_inst_buf_valid_q;
    fs_inst_buf_d       = fs_inst_buf_q;
    fs_pc_d             = fs_pc_q;
    discard_cnt_d       = discard_cnt_q;

    if (flush) begin
      fs_valid_d          = 1'b0;
      fs_inst_buf_valid_d = 1'b0;
      discard_cnt_d       = flush_discard(discard_cnt_q, fs_wait, pfs_inst_waiting,
                                          inst_sram_data_ok);
    end else begin
      if (inst_sram_data_ok && (discard_cnt_q != 2'd0)) begin
        discard_cnt_d = discard_cnt_q - 2'd1;
      end
      // fs_take implies fs_allowin is low, so it never coincides with an accept.
      if (fs_accept) begin
        fs_valid_d          = 1'b1;
        fs_pc_d             = pfs_bus.pc;
        fs_inst_buf_valid_d = pfs_bus.inst_ok;
        if (pfs_bus.inst_ok) begin
          fs_inst_buf_d = pfs_bus.inst;
        end
      end else if (fs_take) begin
        fs_inst_buf_valid_d = 1'b1;
        fs_inst_buf_d       = inst_sram_rdata;
      end else if (fs_ready_go && ds_allowin) begin
        fs_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q          <= 1'b0;
      fs_inst_buf_valid_q <= 1'b0;
      fs_inst_buf_q       <= 32'h0;
      fs_pc_q             <= 32'h0;
      discard_cnt_q       <= 2'd0;
    end else begin
      fs_valid_q          <= fs_valid_d;
      fs_inst_buf_valid_q <= fs_inst_buf_valid_d;
      fs_inst_buf_q       <= fs_inst_buf_d;
      fs_pc_q             <= fs_pc_d;
      discard_cnt_q       <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a slot/drop-count model is compared every cycle, and
// hand-computed literals pin the key scenarios (hit, late data, stall, flush, AdEL, reset).
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pfs_to_fs_valid;
  logic [64:0] pfs_to_fs_bus;
  logic        fs_allowin;
  logic        fs_valid;
  logic        fs_inst_unable;
  logic        pfs_inst_waiting;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [69:0] fs_to_ds_bus;
  logic        ws_ex;
  logic        ws_eret;

  int checks   = 0;
  int failures = 0;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_bus     (pfs_to_fs_bus),
    .fs_allowin        (fs_allowin),
    .fs_valid          (fs_valid),
    .fs_inst_unable    (fs_inst_unable),
    .pfs_inst_waiting  (pfs_inst_waiting),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .ws_ex             (ws_ex),
    .ws_eret           (ws_eret)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [69:0] actual,
                             input logic [69:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: one instruction slot plus a count of returning responses that belong to nobody.
  bit          started = 1'b0;
  bit          slotLive = 1'b0;
  bit          slotHasInst = 1'b0;
  logic [31:0] slotPc = 32'h0;
  logic [31:0] slotInst = 32'h0;
  int          dropPending = 0;

  always @(posedge clk) begin : model
    bit waiting, leaves, takes, accepts;
    int pending;
    if (reset) begin
      started     = 1'b1;
      slotLive    = 1'b0;
      slotHasInst = 1'b0;
      slotPc      = 32'h0;
      slotInst    = 32'h0;
      dropPending = 0;
    end else begin
      waiting = slotLive && !slotHasInst;
      if (ws_ex || ws_eret) begin
        pending = dropPending + (waiting ? 1 : 0) + (pfs_inst_waiting ? 1 : 0)
                  - (inst_sram_data_ok ? 1 : 0);
        if (pending < 0) pending = 0;
        if (pending > 2) pending = 2;
        dropPending = pending;
        slotLive    = 1'b0;
        slotHasInst = 1'b0;
      end else begin
        leaves  = slotLive && slotHasInst && ds_allowin;
        accepts = pfs_to_fs_valid && (!slotLive || leaves);
        takes   = inst_sram_data_ok && waiting && (dropPending == 0);
        if (inst_sram_data_ok && dropPending > 0) dropPending = dropPending - 1;
        if (accepts) begin
          slotLive    = 1'b1;
          slotPc      = pfs_to_fs_bus[31:0];
          slotHasInst = pfs_to_fs_bus[64];
          if (pfs_to_fs_bus[64]) slotInst = pfs_to_fs_bus[63:32];
        end else if (takes) begin
          slotHasInst = 1'b1;
          slotInst    = inst_sram_rdata;
        end else if (leaves) begin
          slotLive = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit expToDs;
    logic [69:0] expBus;
    if (started) begin
      expToDs = slotLive && slotHasInst && !(ws_ex || ws_eret);
      checkBit("model_allowin", fs_allowin, !slotLive || (slotHasInst && ds_allowin));
      checkBit("model_valid", fs_valid, slotLive);
      checkBit("model_unable", fs_inst_unable, (dropPending == 0) && !(slotLive && !slotHasInst));
      checkBit("model_to_ds_valid", fs_to_ds_valid, expToDs);
      if (expToDs) begin
        if ((slotPc % 4) != 0) expBus = {1'b1, 5'h04, 32'h0, slotPc};
        else                   expBus = {1'b0, 5'h00, slotInst, slotPc};
        checkOutput("model_ds_bus", fs_to_ds_bus, expBus);
      end
    end
  end

  task automatic applyStimulus(input logic pfsValid, input logic instOk, input logic [31:0] inst,
                               input logic [31:0] pc, input logic dataOk, input logic [31:0] rdata,
                               input logic dsAllow, input logic pfsWait, input logic ex,
                               input logic eret);
    pfs_to_fs_valid   = pfsValid;
    pfs_to_fs_bus     = {instOk, inst, pc};
    inst_sram_data_ok = dataOk;
    inst_sram_rdata   = rdata;
    ds_allowin        = dsAllow;
    pfs_inst_waiting  = pfsWait;
    ws_ex             = ex;
    ws_eret           = eret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    @(negedge clk);
    checkBit("reset_allowin", fs_allowin, 1'b1);
    checkBit("reset_valid", fs_valid, 1'b0);
    checkBit("reset_unable", fs_inst_unable, 1'b1);
    checkBit("reset_to_ds_valid", fs_to_ds_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Hit path
    applyStimulus(1'b1, 1'b1, 32'h24010001, 32'hbfc00000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("hit_to_ds_valid", fs_to_ds_valid, 1'b1);
    checkOutput("hit_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'h24010001, 32'hbfc00000});
    tick();

    // Late data: two cycles after accept
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("late_unable_wait", fs_inst_unable, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkBit("late_not_yet", fs_to_ds_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("late_to_ds_valid", fs_to_ds_valid, 1'b1);
    checkOutput("late_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'h00000000, 32'hbfc00004});
    tick();

    // Decode stall with a second fetch waiting
    applyStimulus(1'b1, 1'b1, 32'h11111111, 32'hbfc00008, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h22222222, 32'hbfc0000c, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkBit("stall_allowin", fs_allowin, 1'b0);
      checkOutput("stall_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'h11111111, 32'hbfc00008});
      tick();
    end
    ds_allowin = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checkOutput("stall_second", fs_to_ds_bus, {1'b0, 5'h00, 32'h22222222, 32'hbfc0000c});
    tick();

    // Flush while IF and pre-IF both wait: two responses dropped, third delivered
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00010, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00380, 1'b1, 32'hdeadbeef, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkBit("flush_unable_drop", fs_inst_unable, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hcafef00d, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3c1abfc0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkBit("flush_not_yet", fs_to_ds_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("flush_delivered", fs_to_ds_bus, {1'b0, 5'h00, 32'h3c1abfc0, 32'hbfc00380});
    tick();

    // Misaligned PC
    applyStimulus(1'b1, 1'b1, 32'h12345678, 32'hbfc00002, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("adel_to_ds_valid", fs_to_ds_valid, 1'b1);
    checkOutput("adel_bus", fs_to_ds_bus, {1'b1, 5'h04, 32'h0, 32'hbfc00002});
    tick();

    // eret flushes a ready instruction
    applyStimulus(1'b1, 1'b1, 32'h33333333, 32'hbfc00020, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkBit("eret_to_ds_valid", fs_to_ds_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("eret_valid", fs_valid, 1'b0);
    tick();

    // Back-to-back flushes saturate the drop count at two
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00050, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    checkBit("sat_unable_second", fs_inst_unable, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("sat_unable_done", fs_inst_unable, 1'b1);
    tick();

    // Reset while waiting with one response still to drop
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00030, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00034, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("pre_reset_unable", fs_inst_unable, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkBit("post_reset_allowin", fs_allowin, 1'b1);
    checkBit("post_reset_valid", fs_valid, 1'b0);
    checkBit("post_reset_unable", fs_inst_unable, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hbfc00040, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'habcd0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    checkBit("post_reset_to_ds_valid", fs_to_ds_valid, 1'b1);
    checkOutput("post_reset_bus", fs_to_ds_bus, {1'b0, 5'h00, 32'habcd0000, 32'hbfc00040});
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
